// File: rtl/l2_burst_responder_pkg.sv
// Shared types and constants for the L2 burst responder: FSM states, request
// kinds, the pending-request record and the burst-length helper.
package l2_resp_pkg;

  localparam int MAX_BURST_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RFETCH  = 3'd1,
    S_RSTREAM = 3'd2,
    S_WSETUP  = 3'd3,
    S_WCAPT   = 3'd4,
    S_WDRAIN  = 3'd5
  } state_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_t;

  typedef struct packed {
    req_kind_t   kind;
    logic [31:0] base;
    logic [4:0]  last;
  } op_t;

  // Index of the final word of a burst: size 0 means one word, oversize clamps.
  function automatic logic [4:0] eff_last(input logic [4:0] size, input logic [4:0] max_n);
    if (size == 5'd0) return 5'd0;
    if (size > max_n) return max_n - 5'd1;
    return size - 5'd1;
  endfunction

endpackage

// File: rtl/l2_burst_responder_if.sv
// L2-side streaming handshake and backing-memory access bus of the burst responder.
interface l2_burst_responder_if;
  logic        l2_rreq;
  logic        l2_wreq;
  logic [31:0] l2_addr;
  logic [4:0]  l2_burst_size;
  logic [31:0] l2_wdata;
  logic [31:0] l2_rdata;
  logic        l2_busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        proto_err;

  modport slave (
    input  l2_rreq, l2_wreq, l2_addr, l2_burst_size, l2_wdata, mem_rdata, mem_ack,
    output l2_rdata, l2_busy, mem_req, mem_we, mem_addr, mem_wdata, proto_err
  );

  modport master (
    output l2_rreq, l2_wreq, l2_addr, l2_burst_size, l2_wdata, mem_rdata, mem_ack,
    input  l2_rdata, l2_busy, mem_req, mem_we, mem_addr, mem_wdata, proto_err
  );
endinterface

// File: rtl/l2_burst_responder_buf.sv
// Burst word buffer: DEPTH x 32 register file, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module l2_burst_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/l2_burst_responder.sv
// L2 burst responder: buffers read bursts from backing memory before streaming
// them out, and collects write bursts before draining them to memory.
//
// state     | meaning
// S_IDLE    | no operation, ready to accept a request
// S_RFETCH  | reading N words from memory into the buffer, busy=1
// S_RSTREAM | streaming buffered words on l2_rdata, busy=0
// S_WSETUP  | one busy cycle before write data collection
// S_WCAPT   | one dead cycle, then capturing N words of l2_wdata, busy=0
// S_WDRAIN  | writing buffered words to memory, busy=1
module l2_burst_responder
  import l2_resp_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic reset_n,
  l2_burst_responder_if.slave bus
);

  localparam int         AW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [4:0] MAX_N = 5'(MAX_BURST);

  state_t      state;
  logic [31:0] cur_base;
  logic [4:0]  cur_last;
  op_t         pend;
  logic        pend_valid;
  logic [4:0]  cnt;
  logic        primed;

  logic        busy_q;
  logic [31:0] rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        err_q;

  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [AW-1:0] buf_raddr;
  logic [31:0]   buf_wdata;
  logic [31:0]   buf_rdata;

  logic        req_any;
  op_t         req_op;
  logic        cnt_tc;
  logic [4:0]  cnt_nxt;
  logic        can_queue;
  logic        bad_req;
  logic        op_done;
  logic        start_en;
  op_t         start_op;

  assign req_any   = bus.l2_rreq | bus.l2_wreq;
  assign cnt_tc    = (cnt == cur_last);
  assign cnt_nxt   = cnt + 5'd1;
  assign can_queue = req_any && busy_q && !pend_valid;
  assign bad_req   = (bus.l2_rreq && bus.l2_wreq) ||
                     (req_any && (state != S_IDLE) && (!busy_q || pend_valid));
  assign op_done   = ((state == S_RSTREAM) && cnt_tc) ||
                     ((state == S_WDRAIN) && bus.mem_ack && cnt_tc);

  always_comb begin
    req_op.kind = bus.l2_rreq ? REQ_READ : REQ_WRITE;
    req_op.base = bus.l2_addr & ~32'h3;
    req_op.last = eff_last(bus.l2_burst_size, MAX_N);
  end

  // A request arriving on the very edge an operation finishes is started
  // directly instead of passing through the pending slot.
  always_comb begin
    start_en = 1'b0;
    start_op = req_op;
    if (state == S_IDLE) begin
      start_en = req_any;
    end else if (op_done) begin
      start_en = pend_valid || can_queue;
      start_op = pend_valid ? pend : req_op;
    end
  end

  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = cnt[AW-1:0];
    buf_wdata = bus.mem_rdata;
    buf_raddr = '0;
    case (state)
      S_RFETCH:  buf_we = bus.mem_ack;
      S_WCAPT: begin
        buf_we    = primed;
        buf_wdata = bus.l2_wdata;
      end
      S_RSTREAM,
      S_WDRAIN:  buf_raddr = cnt_nxt[AW-1:0];
      default:   buf_raddr = '0;
    endcase
  end

  l2_burst_buf #(.DEPTH(MAX_BURST), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cur_base    <= '0;
      cur_last    <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      cnt         <= '0;
      primed      <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (bad_req) err_q <= 1'b1;

      if (op_done) begin
        pend_valid <= 1'b0;
      end else if (can_queue) begin
        pend       <= req_op;
        pend_valid <= 1'b1;
      end

      case (state)
        S_RFETCH: begin
          if (bus.mem_ack) begin
            if (cnt_tc) begin
              state     <= S_RSTREAM;
              busy_q    <= 1'b0;
              mem_req_q <= 1'b0;
              cnt       <= '0;
              // a one-word burst's only word is still on mem_rdata
              rdata_q   <= (cnt == 5'd0) ? bus.mem_rdata : buf_rdata;
            end else begin
              cnt        <= cnt_nxt;
              mem_addr_q <= mem_addr_q + 32'd4;
            end
          end
        end
        S_RSTREAM: begin
          if (cnt_tc) begin
            state   <= S_IDLE;
            rdata_q <= '0;
          end else begin
            cnt     <= cnt_nxt;
            rdata_q <= buf_rdata;
          end
        end
        S_WSETUP: begin
          state  <= S_WCAPT;
          busy_q <= 1'b0;
          cnt    <= '0;
          primed <= 1'b0;
        end
        S_WCAPT: begin
          if (!primed) begin
            primed <= 1'b1;
          end else if (cnt_tc) begin
            state       <= S_WDRAIN;
            busy_q      <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= cur_base;
            mem_wdata_q <= (cnt == 5'd0) ? bus.l2_wdata : buf_rdata;
            cnt         <= '0;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_WDRAIN: begin
          if (bus.mem_ack) begin
            if (cnt_tc) begin
              state     <= S_IDLE;
              busy_q    <= 1'b0;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
            end else begin
              cnt         <= cnt_nxt;
              mem_addr_q  <= mem_addr_q + 32'd4;
              mem_wdata_q <= buf_rdata;
            end
          end
        end
        default: ;
      endcase

      if (start_en) begin
        cur_base <= start_op.base;
        cur_last <= start_op.last;
        cnt      <= '0;
        primed   <= 1'b0;
        busy_q   <= 1'b1;
        mem_we_q <= 1'b0;
        if (start_op.kind == REQ_READ) begin
          state      <= S_RFETCH;
          mem_req_q  <= 1'b1;
          mem_addr_q <= start_op.base;
        end else begin
          state     <= S_WSETUP;
          mem_req_q <= 1'b0;
        end
      end
    end
  end

  assign bus.l2_busy   = busy_q;
  assign bus.l2_rdata  = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.proto_err = err_q;

endmodule

// File: doc/l2_burst_responder.md
L2_BURST_RESPONDER -- requirements
Module: l2_burst_responder

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 16, giving burst buffer depth in 32-bit words.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low, with ports named clk and reset_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 l2_rreq  input  1  one-cycle read-burst request pulse.
REQ-006 l2_wreq  input  1  one-cycle write-burst request pulse.
REQ-007 l2_addr  input  32  burst start byte address, valid with request; bits [1:0] ignored.
REQ-008 l2_burst_size  input  5  burst length in words, valid with request.
REQ-009 l2_wdata  input  32  write-burst data word.
REQ-010 l2_rdata  output  32  read-burst data word.
REQ-011 l2_busy  output  1  high while the responder cannot stream data.
REQ-012 mem_req, mem_we  output  1 each  backing-memory word access request (held until ack) and write enable.
REQ-013 mem_addr, mem_wdata  output  32 each  memory word address and write data.
REQ-014 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-015 mem_ack  input  1  one-cycle access-complete pulse.
REQ-016 proto_err  output  1  sticky flag: protocol violation seen.

Function
REQ-017 Effective length N SHALL be l2_burst_size, with 0 treated as 1 and values above MAX_BURST clamped to MAX_BURST.
REQ-018 Word k SHALL use address {l2_addr[31:2],2'b00} + 4k, linear and without wrap.
REQ-019 If l2_rreq and l2_wreq are both high, the block SHALL treat the request as a read and set proto_err.
REQ-020 States SHALL be IDLE, RFETCH, RSTREAM, WSETUP, WCAPT and WDRAIN.
REQ-021 In IDLE, a request sampled at edge E SHALL latch address and N, and drive l2_busy=1 from E.
REQ-022 Read path: RFETCH SHALL issue N sequential memory reads into the buffer, one outstanding at a time.
REQ-023 After the Nth mem_ack, RSTREAM SHALL drive l2_busy=0 with l2_rdata=word0 in the same cycle, then word k in the k-th following cycle, for N consecutive cycles, then return to IDLE.
REQ-024 Write path: WSETUP SHALL hold l2_busy=1 for exactly one cycle, after which l2_busy=0 for cycle T.
REQ-025 WCAPT SHALL capture l2_wdata word k at the end of cycle T+1+k for k=0..N-1, with l2_busy=0 throughout.
REQ-026 After the last capture, WDRAIN SHALL assert l2_busy=1, write all N words to memory in order, then go to IDLE (or serve the pending request, REQ-027).
REQ-027 A request arriving while l2_busy=1 SHALL be latched into a single pending slot (type, address, N) and served immediately after the current operation, with l2_busy held 1 continuously.
REQ-028 A request while the pending slot is full, or while l2_busy=0 outside IDLE, SHALL be ignored and set proto_err.
REQ-029 l2_rdata SHALL be 0 outside RSTREAM.
REQ-030 mem_req SHALL deassert in the cycle after mem_ack when no further words remain.

Reset
REQ-031 Reset SHALL asynchronously force IDLE, clear the pending slot, and drive l2_busy, l2_rdata, mem_req, mem_we, mem_addr, mem_wdata and proto_err to 0.
REQ-032 Reset mid-burst SHALL abandon the burst without completing memory writes; buffer contents are not reset.

Structure
REQ-033 Package l2_resp_pkg SHALL hold the state enum, the MAX_BURST default and the request-type constants.
REQ-034 The buffer SHALL be sub-module l2_burst_buf: a MAX_BURST x 32 register file with one write port and one read port.

Verification
REQ-035 Read, addr 0x100, size 8, memory ack latency 2 -> busy=1 during the fetch, then 8 consecutive busy=0 cycles carrying mem[0x100..0x11C].
REQ-036 Write, addr 0x200, size 8, data 0xA0..0xA7 on cycles T+1..T+8 -> memory receives 8 writes, 0x200=0xA0 through 0x21C=0xA7.
REQ-037 Write size 8, then read 0x200 pulsed the cycle after the last data word -> read queued, busy stays 1, read returns 0xA0..0xA7.
REQ-038 Size 0 and size 31 -> 1-word and 16-word bursts respectively; proto_err stays 0.
REQ-039 Request during RSTREAM, and rreq+wreq together -> proto_err=1; the stream is uncorrupted.
REQ-040 reset_n low mid-WDRAIN -> all outputs 0 immediately; a following read of size 1 completes normally.
